// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, x/y counters, sync/blank decode, frame tick.
// Define VGA_PIPE_ALIGN_EN to delay hsync/vsync/video_on by one clk to line up with registered pixel data.
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        px_en,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_MAX  = 4'(DIV - 1);
    localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        px_en_q, tick_q, von_q, hs_q, vs_q;
    logic        step, tick_d, von_d, hs_d, vs_d;

    always_comb begin
        step      = (div_cnt_q == DIV_MAX);
        div_cnt_d = step ? 4'd0 : div_cnt_q + 4'd1;
        x_d       = x_q;
        y_d       = y_q;
        tick_d    = 1'b0;
        if (step) begin
            if (x_q == H_MAX) begin
                x_d = 11'd0;
                if (y_q == V_MAX) begin
                    y_d    = 11'd0;
                    tick_d = 1'b1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
        // Decode from next-state counters so the registered flags line up with x/y.
        von_d = (x_d < H_VIS) && (y_d < V_VIS);
        hs_d  = !((x_d >= HS_START) && (x_d < HS_END));
        vs_d  = !((y_d >= VS_START) && (y_d < VS_END));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= 4'd0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            px_en_q   <= 1'b0;
            tick_q    <= 1'b0;
            von_q     <= 1'b1;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            px_en_q   <= step;
            tick_q    <= tick_d;
            von_q     <= von_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign px_en      = px_en_q;
    assign frame_tick = tick_q;

`ifdef VGA_PIPE_ALIGN_EN
    logic von_p_q, hs_p_q, vs_p_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            von_p_q <= 1'b1;
            hs_p_q  <= 1'b1;
            vs_p_q  <= 1'b1;
        end else begin
            von_p_q <= von_q;
            hs_p_q  <= hs_q;
            vs_p_q  <= vs_q;
        end
    end

    assign video_on = von_p_q;
    assign hsync    = hs_p_q;
    assign vsync    = vs_p_q;
`else
    assign video_on = von_q;
    assign hsync    = hs_q;
    assign vsync    = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default DIV=4 raster, DIV=1 raster, and a shrunken DIV=2 raster for whole-frame timing.
module tb_vga_timing_gen;
`ifdef VGA_PIPE_ALIGN_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_pe, a_vo, a_hs, a_vs, a_ft;
    logic b_pe, b_vo, b_hs, b_vs, b_ft;
    logic c_pe, c_vo, c_hs, c_vs, c_ft;

    vga_timing_gen u_a (.clk(clk), .rst(rst), .x(a_x), .y(a_y), .px_en(a_pe),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft));

    vga_timing_gen #(.DIV(1)) u_b (.clk(clk), .rst(rst), .x(b_x), .y(b_y), .px_en(b_pe),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft));

    // 15 x 10 raster at DIV=2: frame = 300 clks, hsync 6 clks at x=10, vsync 60 clks at y=7.
    vga_timing_gen #(.DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_c (.clk(clk), .rst(rst), .x(c_x), .y(c_y),
        .px_en(c_pe), .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int fall_at;
        int len;
        bit done;
        bit prev;
    } run_t;

    // Records where an active-low-style condition first begins and the length of its first run.
    function automatic run_t track(run_t r, logic low, int pos);
        if (low && !r.prev && r.fall_at < 0) r.fall_at = pos;
        if (low && !r.done) r.len++;
        if (!low && r.len > 0) r.done = 1'b1;
        r.prev = low;
        return r;
    endfunction

    run_t a_hsr = '{-1, 0, 1'b0, 1'b0};
    run_t a_vor = '{-1, 0, 1'b0, 1'b0};
    run_t b_hsr = '{-1, 0, 1'b0, 1'b0};
    run_t c_hsr = '{-1, 0, 1'b0, 1'b0};
    run_t c_vsr = '{-1, 0, 1'b0, 1'b0};
    int a_wrap_e = 0, b_wrap_e = 0, a_vo_rise_e = 0;
    int b_pe_zero = 0, big_ticks = 0;
    int c_ticks = 0, c_t1 = 0, c_t2 = 0, c_tick_bad = 0, c_vo_bad = 0;
    logic c_ft_prev = 1'b0, a_vo_prev = 1'b1;
    logic [10:0] c_y_prev = 11'd0;
    int rst_ticks = 0;

    initial begin
        repeat (10) @(negedge clk);
        chk("rst_x", a_x, 0);
        chk("rst_y", a_y, 0);
        chk("rst_video_on", a_vo, 1);
        chk("rst_hsync", a_hs, 1);
        chk("rst_vsync", a_vs, 1);
        chk("rst_px_en", a_pe, 0);
        chk("rst_frame_tick", c_ft, 0);
        rst = 1'b1;

        for (int e = 1; e <= 3300; e++) begin
            @(negedge clk);
            if (e == 1) begin
                chk("b_px_en_e1", b_pe, 1);
                chk("b_x_e1", b_x, 1);
            end
            if (e == 3) begin
                chk("a_px_en_e3", a_pe, 0);
                chk("a_x_e3", a_x, 0);
            end
            if (e == 4) begin
                chk("a_px_en_e4", a_pe, 1);
                chk("a_x_e4", a_x, 1);
            end
            if (e == 5) chk("a_px_en_e5", a_pe, 0);
            if (e == 8) begin
                chk("a_px_en_e8", a_pe, 1);
                chk("a_x_e8", a_x, 2);
            end
            if (a_wrap_e == 0 && a_x == 0 && a_y == 1) a_wrap_e = e;
            if (b_wrap_e == 0 && b_x == 0 && b_y == 1) b_wrap_e = e;
            a_hsr = track(a_hsr, !a_hs, int'(a_x));
            a_vor = track(a_vor, !a_vo, int'(a_x));
            if (!a_vo_prev && a_vo && a_vo_rise_e == 0) a_vo_rise_e = e;
            a_vo_prev = a_vo;
            b_hsr = track(b_hsr, !b_hs, int'(b_x));
            if (!b_pe) b_pe_zero++;
            if (a_ft || b_ft) big_ticks++;
            c_hsr = track(c_hsr, !c_hs, int'(c_x));
            c_vsr = track(c_vsr, !c_vs, int'(c_y));
            if (c_ft) begin
                c_ticks++;
                if (c_ticks == 1) c_t1 = e;
                if (c_ticks == 2) c_t2 = e;
                if (c_x != 0 || c_y != 0 || !c_pe || c_ft_prev) c_tick_bad++;
            end
            c_ft_prev = c_ft;
            if (c_vo && ((PIPE != 0) ? c_y_prev : c_y) >= 6) c_vo_bad++;
            c_y_prev = c_y;
        end

        chk("a_line_wrap_clks", a_wrap_e, 3200);
        chk("a_hsync_fall_x", a_hsr.fall_at, 656);
        chk("a_hsync_low_clks", a_hsr.len, 384);
        chk("a_video_on_fall_x", a_vor.fall_at, 640);
        chk("a_video_on_rise_clk", a_vo_rise_e, 3200 + PIPE);
        chk("b_line_wrap_clks", b_wrap_e, 800);
        chk("b_px_en_gaps", b_pe_zero, 0);
        chk("b_hsync_fall_x", b_hsr.fall_at, 656 + PIPE);
        chk("b_hsync_low_clks", b_hsr.len, 96);
        chk("ab_no_frame_tick", big_ticks, 0);
        chk("c_first_tick_clk", c_t1, 300);
        chk("c_tick_period", c_t2 - c_t1, 300);
        chk("c_tick_count", c_ticks, 11);
        chk("c_tick_shape", c_tick_bad, 0);
        chk("c_vsync_fall_y", c_vsr.fall_at, 7);
        chk("c_vsync_low_clks", c_vsr.len, 60);
        chk("c_hsync_fall_x", c_hsr.fall_at, 10);
        chk("c_hsync_low_clks", c_hsr.len, 6);
        chk("c_video_on_blank", c_vo_bad, 0);

        // Mid-line reset while the default raster sits inside its hsync pulse.
        for (int i = 0; i < 4000 && a_x != 11'd700; i++) @(negedge clk);
        chk("reach_x700", a_x, 700);
        chk("pre_rst_hsync", a_hs, 0);
        chk("pre_rst_video_on", a_vo, 0);
        rst = 1'b0;
        #1;
        chk("async_x", a_x, 0);
        chk("async_y", a_y, 0);
        chk("async_video_on", a_vo, 1);
        chk("async_hsync", a_hs, 1);
        chk("async_vsync", a_vs, 1);
        chk("async_px_en", a_pe, 0);
        chk("async_c_x", c_x, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (a_ft || b_ft || c_ft) rst_ticks++;
            if (e == 4) chk("re_a_x_e4", a_x, 1);
            if (e == 8) begin
                chk("re_a_x_e8", a_x, 2);
                chk("re_b_x_e8", b_x, 8);
                chk("re_b_y_e8", b_y, 0);
            end
        end
        chk("re_no_frame_tick", rst_ticks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
